// File: rtl/i2c_txn_sequencer_if.sv
// Request, byte-engine command and response bundle for the I2C
// register-access transaction sequencer.
interface i2c_txn_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_dev_addr;
    logic [7:0] req_reg_addr;
    logic [7:0] req_wdata;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_nack_last;
    logic       cmd_done;
    logic       cmd_nack;
    logic [7:0] cmd_rdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;

    modport master (
        input  req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
        input  cmd_ready, cmd_done, cmd_nack, cmd_rdata,
        output req_ready, cmd_valid, cmd_op, cmd_data, cmd_nack_last,
        output rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
    );

    modport slave (
        output req_valid, req_rw, req_dev_addr, req_reg_addr, req_wdata,
        output cmd_ready, cmd_done, cmd_nack, cmd_rdata,
        input  req_ready, cmd_valid, cmd_op, cmd_data, cmd_nack_last,
        input  rsp_valid, rsp_rdata, rsp_nack, rsp_timeout
    );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Turns one register read/write request into a START/WRITE/READ/STOP
// command stream for an I2C byte engine, with NACK and timeout abort.
module i2c_txn_sequencer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input logic             clk,
    input logic             rst_n,
    i2c_txn_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_START, S_DEV_W, S_REG, S_DATA_W,
        S_RESTART, S_DEV_R, S_DATA_R, S_STOP, S_RESP
    } state_t;

    state_t      r_state, w_next, w_seq;
    logic        r_issue, w_issue_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic        r_nack, w_nack_next;
    logic        r_to, w_to_next;
    logic        r_rw;
    logic [6:0]  r_dev;
    logic [7:0]  r_reg, r_wdata, r_cap, r_rdata;
    logic        w_cmd_st, w_nack_st, w_expire, w_accept;
    logic [16:0] w_cnt_inc;

    assign w_cmd_st  = !(r_state inside {S_IDLE, S_RESP});
    assign w_nack_st = r_state inside {S_DEV_W, S_REG, S_DATA_W, S_DEV_R};
    assign w_accept  = (r_state == S_IDLE) & bus.req_valid;
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_expire  = (w_cnt_inc == {1'b0, TIMEOUT_CYCLES});

    always_comb begin
        w_seq = S_IDLE;
        unique case (r_state)
            S_START:   w_seq = S_DEV_W;
            S_DEV_W:   w_seq = S_REG;
            S_REG:     w_seq = r_rw ? S_RESTART : S_DATA_W;
            S_DATA_W:  w_seq = S_STOP;
            S_RESTART: w_seq = S_DEV_R;
            S_DEV_R:   w_seq = S_DATA_R;
            S_DATA_R:  w_seq = S_STOP;
            S_STOP:    w_seq = S_RESP;
            default:   w_seq = S_IDLE;
        endcase
    end

    // Issue phase holds the counter at zero; only wait cycles count.
    always_comb begin
        w_next       = r_state;
        w_issue_next = r_issue;
        w_cnt_next   = r_cnt;
        w_nack_next  = r_nack;
        w_to_next    = r_to;
        if (r_state == S_IDLE) begin
            if (bus.req_valid) begin
                w_next       = S_START;
                w_issue_next = 1'b1;
            end
        end else if (r_state == S_RESP) begin
            w_next      = S_IDLE;
            w_nack_next = 1'b0;
            w_to_next   = 1'b0;
        end else if (r_issue) begin
            w_cnt_next = '0;
            if (bus.cmd_ready) w_issue_next = 1'b0;
        end else if (bus.cmd_done) begin
            w_cnt_next   = '0;
            w_issue_next = 1'b1;
            if (w_nack_st && bus.cmd_nack) begin
                w_nack_next = 1'b1;
                w_next      = S_STOP;
            end else begin
                w_next = w_seq;
            end
        end else if (w_expire) begin
            w_cnt_next   = '0;
            w_issue_next = 1'b1;
            w_to_next    = 1'b1;
            w_next       = (r_state == S_STOP) ? S_RESP : S_STOP;
        end else begin
            w_cnt_next = w_cnt_inc[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_issue <= 1'b1;
            r_cnt   <= '0;
            r_nack  <= 1'b0;
            r_to    <= 1'b0;
            r_rw    <= 1'b0;
            r_dev   <= '0;
            r_reg   <= '0;
            r_wdata <= '0;
            r_cap   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_issue <= w_issue_next;
            r_cnt   <= w_cnt_next;
            r_nack  <= w_nack_next;
            r_to    <= w_to_next;
            if (w_accept) begin
                r_rw    <= bus.req_rw;
                r_dev   <= bus.req_dev_addr;
                r_reg   <= bus.req_reg_addr;
                r_wdata <= bus.req_wdata;
                r_cap   <= '0;
            end
            if (r_state == S_DATA_R && !r_issue && bus.cmd_done)
                r_cap <= bus.cmd_rdata;
            if (w_next == S_RESP && r_state == S_STOP)
                r_rdata <= (r_rw && !w_nack_next && !w_to_next) ? r_cap : 8'h00;
        end
    end

    always_comb begin
        bus.cmd_op   = 3'd0;
        bus.cmd_data = 8'h00;
        unique case (r_state)
            S_START:   bus.cmd_op = 3'd0;
            S_DEV_W: begin
                bus.cmd_op   = 3'd1;
                bus.cmd_data = {r_dev, 1'b0};
            end
            S_REG: begin
                bus.cmd_op   = 3'd1;
                bus.cmd_data = r_reg;
            end
            S_DATA_W: begin
                bus.cmd_op   = 3'd1;
                bus.cmd_data = r_wdata;
            end
            S_RESTART: bus.cmd_op = 3'd4;
            S_DEV_R: begin
                bus.cmd_op   = 3'd1;
                bus.cmd_data = {r_dev, 1'b1};
            end
            S_DATA_R:  bus.cmd_op = 3'd2;
            S_STOP:    bus.cmd_op = 3'd3;
            default:   bus.cmd_op = 3'd0;
        endcase
    end

    assign bus.req_ready     = (r_state == S_IDLE);
    assign bus.cmd_valid     = w_cmd_st & r_issue;
    assign bus.cmd_nack_last = 1'b1;
    assign bus.rsp_valid     = (r_state == S_RESP);
    assign bus.rsp_rdata     = r_rdata;
    assign bus.rsp_nack      = (r_state == S_RESP) & r_nack;
    assign bus.rsp_timeout   = (r_state == S_RESP) & r_to;
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed plus random transactions against a byte-engine responder,
// checked by a transaction-level model of the expected command stream.
module tb_i2c_txn_sequencer;
    localparam logic [15:0] TO = 16'd8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    i2c_txn_sequencer_if bus();

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // engine knobs, indexed by command position within a transaction
    int          k_delay = 3;
    logic [15:0] k_nodone = '0;
    int          k_late = -1;
    int          k_nack = -1;
    int          k_stall_idx = -1;
    int          k_stall_len = 0;
    logic [7:0]  k_rdata = '0;

    logic [10:0] log_q[$];
    int          hs_cyc[$];
    bit          e_busy = 0;
    int          e_cnt = 0;
    int          e_delay = 0;
    bit          e_nk = 0;
    int          e_stall = 0;
    logic [10:0] e_hold = '0;
    int          viol = 0;

    int          rsp_n = 0;
    logic        s_nk, s_to, s_rdy;
    logic [7:0]  s_rd;

    initial begin
        bus.req_valid = 0;
        bus.req_rw = 0;
        bus.req_dev_addr = '0;
        bus.req_reg_addr = '0;
        bus.req_wdata = '0;
        bus.cmd_ready = 1;
        bus.cmd_done = 0;
        bus.cmd_nack = 0;
        bus.cmd_rdata = '0;
    end

    // byte engine responder: all decisions made on the falling edge
    always @(negedge clk) begin
        int idx;
        bus.cmd_done  = 1'b0;
        bus.cmd_nack  = 1'b0;
        bus.cmd_ready = 1'b1;
        bus.cmd_rdata = 8'($urandom);
        idx = log_q.size();
        if (bus.cmd_valid) begin
            if (idx == k_stall_idx && e_stall < k_stall_len) begin
                if (e_stall == 0) e_hold = {bus.cmd_op, bus.cmd_data};
                else if ({bus.cmd_op, bus.cmd_data} !== e_hold) viol++;
                e_stall++;
                bus.cmd_ready = 1'b0;
            end else begin
                if (idx == k_stall_idx && k_stall_len > 0 &&
                    {bus.cmd_op, bus.cmd_data} !== e_hold) viol++;
                if (bus.cmd_nack_last !== 1'b1) viol++;
                log_q.push_back({bus.cmd_op, bus.cmd_data});
                hs_cyc.push_back(cyc);
                e_busy  = 1;
                e_cnt   = 0;
                e_nk    = (idx == k_nack);
                if (idx < 16 && k_nodone[idx]) e_delay = 0;
                else if (idx == k_late) e_delay = int'(TO);
                else e_delay = k_delay;
            end
        end else if (e_busy) begin
            e_cnt++;
            if (e_delay != 0 && e_cnt == e_delay) begin
                bus.cmd_done  = 1'b1;
                bus.cmd_nack  = e_nk;
                bus.cmd_rdata = k_rdata;
                e_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            rsp_n++;
            s_nk  = bus.rsp_nack;
            s_to  = bus.rsp_timeout;
            s_rd  = bus.rsp_rdata;
            s_rdy = bus.req_ready;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // reference model: expected command list and response flags
    logic [10:0] m_q[$];
    bit          m_nk, m_to;
    logic [7:0]  m_rd;

    task automatic model(input bit rw, input logic [6:0] dev,
                         input logic [7:0] ra, input logic [7:0] wd,
                         input logic [7:0] rd);
        logic [10:0] seq[$];
        bit ab;
        int p;
        seq = {};
        seq.push_back({3'd0, 8'h00});
        seq.push_back({3'd1, dev, 1'b0});
        seq.push_back({3'd1, ra});
        if (!rw) begin
            seq.push_back({3'd1, wd});
        end else begin
            seq.push_back({3'd4, 8'h00});
            seq.push_back({3'd1, dev, 1'b1});
            seq.push_back({3'd2, 8'h00});
        end
        seq.push_back({3'd3, 8'h00});
        m_q = {};
        m_nk = 0;
        m_to = 0;
        ab = 0;
        for (int i = 0; i < seq.size(); i++) begin
            m_q.push_back(seq[i]);
            if (seq[i][10:8] == 3'd3) begin
                if (k_nodone[i]) m_to = 1;
                break;
            end
            if (k_nodone[i]) begin
                m_to = 1;
                ab = 1;
            end else if (i == k_nack && seq[i][10:8] == 3'd1) begin
                m_nk = 1;
                ab = 1;
            end
            if (ab) begin
                p = m_q.size();
                m_q.push_back({3'd3, 8'h00});
                if (k_nodone[p]) m_to = 1;
                break;
            end
        end
        m_rd = (rw && !m_nk && !m_to) ? rd : 8'h00;
    endtask

    task automatic start_txn(input bit rw, input logic [6:0] dev,
                             input logic [7:0] ra, input logic [7:0] wd,
                             input logic [7:0] rd, input string tag);
        int b;
        log_q = {};
        hs_cyc = {};
        e_stall = 0;
        k_rdata = rd;
        model(rw, dev, ra, wd, rd);
        @(negedge clk);
        bus.req_rw = rw;
        bus.req_dev_addr = dev;
        bus.req_reg_addr = ra;
        bus.req_wdata = wd;
        bus.req_valid = 1;
        b = 0;
        while (bus.req_ready !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        @(posedge clk);
        #1;
        bus.req_valid = 0;
        bus.req_wdata = 8'($urandom);
        bus.req_reg_addr = 8'($urandom);
    endtask

    task automatic finish_txn(input string tag);
        int n0;
        int b;
        n0 = rsp_n;
        b = 0;
        while (rsp_n == n0 && b < 3000) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_rsp_count"}, 32'(rsp_n - n0), 1);
        chk({tag, "_nops"}, 32'(log_q.size()), 32'(m_q.size()));
        for (int i = 0; i < m_q.size() && i < log_q.size(); i++)
            chk($sformatf("%s_op%0d", tag, i), 32'(log_q[i]), 32'(m_q[i]));
        chk({tag, "_nack"}, 32'(s_nk), 32'(m_nk));
        chk({tag, "_timeout"}, 32'(s_to), 32'(m_to));
        chk({tag, "_rdata"}, 32'(s_rd), 32'(m_rd));
        chk({tag, "_ready_in_resp"}, 32'(s_rdy), 0);
    endtask

    task automatic knobs_default();
        k_delay = 3;
        k_nodone = '0;
        k_late = -1;
        k_nack = -1;
        k_stall_idx = -1;
        k_stall_len = 0;
    endtask

    initial begin
        int b;
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 0);
        chk("rst_cmd_op", 32'(bus.cmd_op), 0);
        chk("rst_cmd_data", 32'(bus.cmd_data), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 0);
        chk("rst_rsp_nack", 32'(bus.rsp_nack), 0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 1);

        knobs_default();
        start_txn(0, 7'h50, 8'h10, 8'hA5, 8'h00, "wr");
        finish_txn("wr");
        chk("wr_dev_byte", 32'(log_q[1]), 32'({3'd1, 8'hA0}));

        start_txn(1, 7'h50, 8'h20, 8'h00, 8'h3C, "rd");
        finish_txn("rd");
        chk("rd_rdata_const", 32'(s_rd), 32'h3C);
        chk("rd_devr_byte", 32'(log_q[4]), 32'({3'd1, 8'hA1}));
        repeat (5) @(negedge clk);
        chk("rd_rdata_held", 32'(bus.rsp_rdata), 32'h3C);

        knobs_default();
        k_nack = 1;
        start_txn(0, 7'h50, 8'h10, 8'hA5, 8'h00, "nack");
        finish_txn("nack");
        chk("nack_stop_next", 32'(log_q[2]), 32'({3'd3, 8'h00}));

        knobs_default();
        k_nodone = 16'b1100;
        start_txn(0, 7'h50, 8'h10, 8'hA5, 8'h00, "tmo");
        finish_txn("tmo");
        if (hs_cyc.size() >= 4)
            chk("tmo_gap", 32'(hs_cyc[3] - hs_cyc[2]), 32'(TO) + 1);
        else
            chk("tmo_hs_count", 32'(hs_cyc.size()), 4);

        knobs_default();
        k_stall_idx = 1;
        k_stall_len = 10;
        start_txn(0, 7'h2A, 8'h33, 8'h5E, 8'h00, "stall");
        finish_txn("stall");
        chk("stall_stable", 32'(viol), 0);
        chk("stall_len", 32'(e_stall), 10);

        knobs_default();
        k_late = 2;
        start_txn(1, 7'h11, 8'h44, 8'h00, 8'h9D, "late");
        finish_txn("late");

        for (int t = 0; t < 12; t++) begin
            knobs_default();
            k_delay = int'($urandom_range(1, 7));
            if ($urandom_range(0, 2) == 0) k_nack = int'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0)
                k_nodone[$urandom_range(0, 7)] = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                k_stall_idx = int'($urandom_range(0, 6));
                k_stall_len = int'($urandom_range(1, 12));
            end
            start_txn(1'($urandom), 7'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom), $sformatf("rnd%0d", t));
            finish_txn($sformatf("rnd%0d", t));
        end
        chk("rnd_stable", 32'(viol), 0);

        knobs_default();
        k_delay = 6;
        n0 = rsp_n;
        start_txn(0, 7'h50, 8'h10, 8'hA5, 8'h00, "mrst");
        b = 0;
        while (log_q.size() < 4 && b < 500) begin
            @(negedge clk);
            b++;
        end
        chk("mrst_reach_dataw", 32'(log_q.size()), 4);
        @(negedge clk);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("mrst_req_ready", 32'(bus.req_ready), 1);
        chk("mrst_cmd_valid", 32'(bus.cmd_valid), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        chk("mrst_no_stop", 32'(log_q.size()), 4);
        chk("mrst_no_rsp", 32'(rsp_n - n0), 0);

        knobs_default();
        start_txn(1, 7'h3F, 8'h01, 8'h00, 8'hC7, "post");
        finish_txn("post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=stuck expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
